// File: rtl/npu_pkg.sv
// npu_pkg: shared constants and types for the layer sequencer.
//   ADDR_W    - width of input-memory and weight addresses (and beat counter)
//   LANES     - number of PE lanes driven by mac_en / act_fn_en
//   LAYER_W   - width of the layer index
//   LANE_ALL  - enable pattern for all lanes
//   seq_state_e - sequencer state encoding
package npu_pkg;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned LANES   = 4;
  localparam int unsigned LAYER_W = 4;

  localparam logic [LANES-1:0] LANE_ALL = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_MAC     = 3'd2,
    S_ACT     = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5
  } seq_state_e;

  // Beat count for a layer: first layer uses the input count, later ones the hidden width.
  function automatic logic [ADDR_W-1:0] beat_limit(input logic first_layer,
                                                    input int unsigned n_l0,
                                                    input int unsigned n_hl);
    return first_layer ? ADDR_W'(n_l0) : ADDR_W'(n_hl);
  endfunction

endpackage

// File: rtl/beat_counter.sv
// beat_counter: counts accepted weight beats within one MAC phase.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   load     - clear the count (entry into MAC)
//   en       - one beat accepted this cycle
//   limit    - number of beats in the current layer
//   tc_c     - combinational: this enabled beat is the last one of the layer
module beat_counter
  import npu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [ADDR_W-1:0] limit,
  output logic              tc_c
);

  logic [ADDR_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      count <= '0;
    end else if (en) begin
      count <= count + ADDR_W'(1);
    end
  end

  assign tc_c = en && (count == limit - ADDR_W'(1));

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: steps a small MLP through its layers. For each layer it
// requests a weight stream, runs one MAC beat per valid weight word, holds the
// activation stage for ACT_LAT cycles, then either captures accumulators into
// the inter-layer buffer or flags the final results.
// Ports:
//   clk, rst       - clock and synchronous active-high reset
//   start          - run request, honoured only when idle
//   w_ack, w_valid - arbiter grant / weight word valid
//   busy, done     - run in progress / one-cycle completion pulse
//   w_req          - weight stream request
//   mac_en         - per-lane MAC enable
//   act_fn_en      - per-lane activation enable
//   feed_through   - capture accumulators into inter-layer buffer
//   res_valid      - final-layer results valid
//   buf_shift      - advance inter-layer buffer one word
//   in_sel         - operand source: 0 input memory, 1 inter-layer buffer
//   in_addr        - input memory address
//   w_addr         - weight word address
//   layer_no       - current layer index
// All outputs are registers updated alongside the state register.
module layer_sequencer
  import npu_pkg::*;
#(
  parameter int unsigned N_INPUTS_L0  = 785,
  parameter int unsigned N_HIDDEN     = 2,
  parameter int unsigned N_NEURONS_HL = 28,
  parameter int unsigned ACT_LAT      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               w_ack,
  input  logic               w_valid,
  output logic               busy,
  output logic               done,
  output logic               w_req,
  output logic [LANES-1:0]   mac_en,
  output logic [LANES-1:0]   act_fn_en,
  output logic               feed_through,
  output logic               res_valid,
  output logic               buf_shift,
  output logic               in_sel,
  output logic [ADDR_W-1:0]  in_addr,
  output logic [ADDR_W-1:0]  w_addr,
  output logic [LAYER_W-1:0] layer_no
);

  localparam int unsigned ACT_W = (ACT_LAT > 1) ? $clog2(ACT_LAT) : 1;

  seq_state_e        state;
  logic [ACT_W-1:0]  act_cnt;
  logic              first_layer;
  logic              final_layer;
  logic              beat_load;
  logic              beat_en;
  logic              beat_last;
  logic [ADDR_W-1:0] limit;

  assign first_layer = (layer_no == '0);
  assign final_layer = (layer_no == LAYER_W'(N_HIDDEN));
  assign limit       = beat_limit(first_layer, N_INPUTS_L0, N_NEURONS_HL);

  // Counter restarts on the grant edge so every MAC phase begins at zero.
  assign beat_load = (state == S_FETCH) && w_ack;
  assign beat_en   = (state == S_MAC) && w_valid;

  beat_counter u_beat_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (beat_load),
    .en    (beat_en),
    .limit (limit),
    .tc_c  (beat_last)
  );

  // State and registered outputs; outputs reflect the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      act_cnt      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      w_req        <= 1'b0;
      mac_en       <= '0;
      act_fn_en    <= '0;
      feed_through <= 1'b0;
      res_valid    <= 1'b0;
      buf_shift    <= 1'b0;
      in_sel       <= 1'b0;
      in_addr      <= '0;
      w_addr       <= '0;
      layer_no     <= '0;
    end else begin
      // Single-cycle strobes default low.
      mac_en       <= '0;
      buf_shift    <= 1'b0;
      feed_through <= 1'b0;
      res_valid    <= 1'b0;
      done         <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            busy     <= 1'b1;
            w_req    <= 1'b1;
            in_sel   <= 1'b0;
            in_addr  <= '0;
            w_addr   <= '0;
            layer_no <= '0;
          end
        end

        S_FETCH: begin
          if (w_ack) begin
            state <= S_MAC;
            w_req <= 1'b0;
          end
        end

        S_MAC: begin
          // A low w_valid is a stall: nothing advances.
          if (w_valid) begin
            mac_en <= LANE_ALL;
            w_addr <= w_addr + ADDR_W'(1);
            if (first_layer) begin
              in_addr <= in_addr + ADDR_W'(1);
            end else begin
              buf_shift <= 1'b1;
            end
            if (beat_last) begin
              state     <= S_ACT;
              act_fn_en <= LANE_ALL;
              act_cnt   <= '0;
            end
          end
        end

        S_ACT: begin
          if (act_cnt == ACT_W'(ACT_LAT - 1)) begin
            state     <= S_CAPTURE;
            act_fn_en <= '0;
            if (final_layer) begin
              res_valid <= 1'b1;
            end else begin
              feed_through <= 1'b1;
            end
          end else begin
            act_cnt <= act_cnt + ACT_W'(1);
          end
        end

        S_CAPTURE: begin
          if (final_layer) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state    <= S_FETCH;
            w_req    <= 1'b1;
            in_sel   <= 1'b1;
            layer_no <= layer_no + LAYER_W'(1);
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          w_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed, table-driven bench for layer_sequencer using a
// 4-input, 2-hidden-layer, 3-neuron, ACT_LAT=2 configuration. Cycle k counts
// from the first cycle after the edge that samples start.
module tb_layer_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       w_ack;
  logic       w_valid;
  logic       busy;
  logic       done;
  logic       w_req;
  logic [3:0] mac_en;
  logic [3:0] act_fn_en;
  logic       feed_through;
  logic       res_valid;
  logic       buf_shift;
  logic       in_sel;
  logic [9:0] in_addr;
  logic [9:0] w_addr;
  logic [3:0] layer_no;

  int checks = 0;
  int errors = 0;

  layer_sequencer #(
    .N_INPUTS_L0  (4),
    .N_HIDDEN     (2),
    .N_NEURONS_HL (3),
    .ACT_LAT      (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .w_ack        (w_ack),
    .w_valid      (w_valid),
    .busy         (busy),
    .done         (done),
    .w_req        (w_req),
    .mac_en       (mac_en),
    .act_fn_en    (act_fn_en),
    .feed_through (feed_through),
    .res_valid    (res_valid),
    .buf_shift    (buf_shift),
    .in_sel       (in_sel),
    .in_addr      (in_addr),
    .w_addr       (w_addr),
    .layer_no     (layer_no)
  );

  always #5 clk = ~clk;

  // One run: stimulus windows plus hand-computed expectations.
  typedef struct {
    int ack_lo_from;  // w_ack held low for cycles in [from, to]
    int ack_lo_to;
    int val_lo_from;  // w_valid held low for cycles in [from, to]
    int val_lo_to;
    int restart_k;    // cycle in which start is pulsed again (0 = never)
    int exp_lat;      // cycle in which done is high
    int exp_mac;      // cycles with mac_en == 4'hf
    int exp_buf;      // buf_shift pulses
    int exp_ft;       // feed_through pulses
    int exp_rv;       // res_valid pulses
    int exp_act;      // cycles with act_fn_en == 4'hf
    int exp_wreq;     // cycles with w_req high
    int chk_k;        // spot-check cycle
    int ck_in_addr;
    int ck_mac;
    int ck_wreq;
    int fin_in_addr;  // values held after the run
    int fin_w_addr;
    int fin_layer;
  } scn_t;

  scn_t scns[4];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic run_scn(input int idx, input scn_t s);
    int lat, n_mac, n_buf, n_ft, n_rv, n_done, n_act, n_wreq, n_busy;
    lat = 0; n_mac = 0; n_buf = 0; n_ft = 0; n_rv = 0;
    n_done = 0; n_act = 0; n_wreq = 0; n_busy = 0;
    @(negedge clk);
    start = 1'b1; w_ack = 1'b1; w_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start   = (k == s.restart_k);
      w_ack   = !(k >= s.ack_lo_from && k <= s.ack_lo_to);
      w_valid = !(k >= s.val_lo_from && k <= s.val_lo_to);
      if (mac_en == 4'hf)    n_mac++;
      if (act_fn_en == 4'hf) n_act++;
      if (buf_shift)         n_buf++;
      if (feed_through)      n_ft++;
      if (res_valid)         n_rv++;
      if (w_req)             n_wreq++;
      if (busy)              n_busy++;
      if (done) begin
        n_done++;
        if (lat == 0) lat = k;
      end
      if (k == s.chk_k) begin
        check($sformatf("s%0d in_addr@%0d", idx, k), int'(in_addr), s.ck_in_addr);
        check($sformatf("s%0d mac_en@%0d", idx, k), int'(mac_en), s.ck_mac);
        check($sformatf("s%0d w_req@%0d", idx, k), int'(w_req), s.ck_wreq);
      end
    end
    check($sformatf("s%0d done_latency", idx), lat, s.exp_lat);
    check($sformatf("s%0d done_count", idx), n_done, 1);
    check($sformatf("s%0d busy_cycles", idx), n_busy, s.exp_lat);
    check($sformatf("s%0d mac_en_cycles", idx), n_mac, s.exp_mac);
    check($sformatf("s%0d act_fn_en_cycles", idx), n_act, s.exp_act);
    check($sformatf("s%0d buf_shift_pulses", idx), n_buf, s.exp_buf);
    check($sformatf("s%0d feed_through_pulses", idx), n_ft, s.exp_ft);
    check($sformatf("s%0d res_valid_pulses", idx), n_rv, s.exp_rv);
    check($sformatf("s%0d w_req_cycles", idx), n_wreq, s.exp_wreq);
    check($sformatf("s%0d final_in_addr", idx), int'(in_addr), s.fin_in_addr);
    check($sformatf("s%0d final_w_addr", idx), int'(w_addr), s.fin_w_addr);
    check($sformatf("s%0d final_layer_no", idx), int'(layer_no), s.fin_layer);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " done"}, int'(done), 0);
    check({tag, " w_req"}, int'(w_req), 0);
    check({tag, " mac_en"}, int'(mac_en), 0);
    check({tag, " act_fn_en"}, int'(act_fn_en), 0);
    check({tag, " feed_through"}, int'(feed_through), 0);
    check({tag, " res_valid"}, int'(res_valid), 0);
    check({tag, " buf_shift"}, int'(buf_shift), 0);
    check({tag, " in_sel"}, int'(in_sel), 0);
    check({tag, " in_addr"}, int'(in_addr), 0);
    check({tag, " w_addr"}, int'(w_addr), 0);
    check({tag, " layer_no"}, int'(layer_no), 0);
  endtask

  initial begin
    int n_pulse;
    // Nominal: 8 + 7 + 7 + 1 = 23 cycles; 4+3+3 MAC beats.
    scns[0] = '{0, -1, 0, -1, 0, 23, 10, 6, 2, 1, 6, 3, 3, 1, 15, 0, 4, 10, 2};
    // w_valid low in cycles 3..5 of layer 0 MAC (cycles 2..8): +3.
    scns[1] = '{0, -1, 3, 5, 0, 26, 10, 6, 2, 1, 6, 3, 5, 1, 0, 0, 4, 10, 2};
    // w_ack low in cycles 9..13, layer 1 FETCH spans 9..14: +5.
    scns[2] = '{9, 13, 0, -1, 0, 28, 10, 6, 2, 1, 6, 8, 12, 4, 0, 1, 4, 10, 2};
    // start re-pulsed in cycle 10 while busy.
    scns[3] = '{0, -1, 0, -1, 10, 23, 10, 6, 2, 1, 6, 3, 3, 1, 15, 0, 4, 10, 2};

    rst = 1'b1; start = 1'b0; w_ack = 1'b0; w_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_scn(i, scns[i]);
    end

    // Reset at the second layer-1 MAC beat (layer-1 MAC occupies cycles 10..12).
    @(negedge clk);
    start = 1'b1; w_ack = 1'b1; w_valid = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 11) begin
        check("mid_reset in_sel before", int'(in_sel), 1);
        check("mid_reset layer_no before", int'(layer_no), 1);
        rst = 1'b1;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("mid_reset");
    n_pulse = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (feed_through || res_valid || done || busy) n_pulse++;
    end
    check("mid_reset stray_activity", n_pulse, 0);

    run_scn(4, scns[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
